// File: rtl/rem_string_feeder.sv
// Regex front end: accepts wide string words and serialises them to one char per cycle,
// marking string ends. Define REM_FEEDER_TRUNC_EN to add MAX_LEN truncation and the truncated output.
module rem_string_feeder #(
    parameter int         WORD_BYTES = 8,
    parameter logic [7:0] DELIMITER  = 8'h00,
    parameter int         MAX_LEN    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_BYTES*8-1:0] in_data,
    input  logic                    in_last,
    input  logic                    out_ready,
    input  logic                    abort,
    output logic                    char_valid,
    output logic [7:0]              char_data,
    output logic                    char_last,
    output logic                    index_rewind,
`ifdef REM_FEEDER_TRUNC_EN
    output logic                    truncated,
`endif
    output logic [31:0]             strings_done
);

    localparam int PW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(WORD_BYTES - 1);

    if (WORD_BYTES < 2 || WORD_BYTES > 64 || MAX_LEN < 1) begin : g_param_check
        $error("rem_string_feeder: illegal WORD_BYTES or MAX_LEN");
    end

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_SKIP} state_e;

    state_e                       state_q, state_d;
    logic [WORD_BYTES-1:0][7:0]   hold_q, hold_d;
    logic                         hold_last_q, hold_last_d;
    logic [PW-1:0]                ptr_q, ptr_d;
    logic                         char_valid_q, char_valid_d;
    logic [7:0]                   char_data_q, char_data_d;
    logic                         char_last_q, char_last_d;
    logic                         rewind_q, rewind_d;
    logic [31:0]                  done_q, done_d;

    logic [7:0] cur_byte;
    logic       at_last, nat_end, str_end, to_skip, accept;

    assign cur_byte = hold_q[ptr_q];
    assign at_last  = (ptr_q == PTR_LAST);
    assign nat_end  = (cur_byte == DELIMITER) || (hold_last_q && at_last);

`ifdef REM_FEEDER_TRUNC_EN
    localparam int LW = $clog2(MAX_LEN + 1);
    logic [LW-1:0] len_q, len_d;
    logic          trunc_q, trunc_d;
    logic          trunc_end;

    assign trunc_end = (len_q == LW'(MAX_LEN - 1)) && !nat_end;
    assign str_end   = nat_end || trunc_end;
    assign truncated = trunc_q;
`else
    assign str_end   = nat_end;
`endif

    // An end on a word without in_last leaves the rest of the string to be skipped,
    // so the next word must not be taken as fresh string data.
    assign to_skip  = str_end && !hold_last_q;
    assign in_ready = !abort &&
                      ((state_q != S_EMIT) || (out_ready && at_last && !to_skip));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_last_d  = hold_last_q;
        ptr_d        = ptr_q;
        char_valid_d = 1'b0;
        char_data_d  = char_data_q;
        char_last_d  = 1'b0;
        rewind_d     = 1'b0;
        done_d       = done_q;
`ifdef REM_FEEDER_TRUNC_EN
        len_d        = len_q;
        trunc_d      = 1'b0;
`endif
        if (abort) begin
            state_d  = S_IDLE;
            ptr_d    = '0;
            rewind_d = 1'b1;
`ifdef REM_FEEDER_TRUNC_EN
            len_d    = '0;
`endif
        end else begin
            case (state_q)
                S_EMIT: begin
                    if (out_ready) begin
                        char_valid_d = 1'b1;
                        char_data_d  = cur_byte;
                        ptr_d        = at_last ? '0 : ptr_q + PW'(1);
`ifdef REM_FEEDER_TRUNC_EN
                        len_d        = len_q + LW'(1);
`endif
                        if (str_end) begin
                            char_last_d = 1'b1;
                            done_d      = done_q + 32'd1;
                            ptr_d       = '0;
                            state_d     = to_skip ? S_SKIP : S_IDLE;
`ifdef REM_FEEDER_TRUNC_EN
                            len_d       = '0;
                            trunc_d     = trunc_end;
`endif
                        end else if (at_last) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_SKIP: begin
                    if (accept && in_last) state_d = S_IDLE;
                end
                default: ;
            endcase
            if (accept && state_q != S_SKIP) begin
                hold_d      = in_data;
                hold_last_d = in_last;
                ptr_d       = '0;
                state_d     = S_EMIT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_last_q  <= 1'b0;
            ptr_q        <= '0;
            char_valid_q <= 1'b0;
            char_data_q  <= 8'h00;
            char_last_q  <= 1'b0;
            rewind_q     <= 1'b0;
            done_q       <= 32'd0;
`ifdef REM_FEEDER_TRUNC_EN
            len_q        <= '0;
            trunc_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_last_q  <= hold_last_d;
            ptr_q        <= ptr_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
            char_last_q  <= char_last_d;
            rewind_q     <= rewind_d;
            done_q       <= done_d;
`ifdef REM_FEEDER_TRUNC_EN
            len_q        <= len_d;
            trunc_q      <= trunc_d;
`endif
        end
    end

    // Word payload carries no reset; validity lives in state_q.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign char_valid   = char_valid_q;
    assign char_data    = char_data_q;
    assign char_last    = char_last_q;
    assign index_rewind = rewind_q;
    assign strings_done = done_q;

endmodule

// File: tb/tb_rem_string_feeder.sv
// Bench for rem_string_feeder: directed timing scenarios plus randomized words checked
// against a string-level reference model of the expected character stream.
module tb_rem_string_feeder;

    localparam int         WB    = 8;
    localparam logic [7:0] DELIM = 8'h00;
`ifdef REM_FEEDER_TRUNC_EN
    localparam int         MAXL  = 4;
`else
    localparam int         MAXL  = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WB*8-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic          abort = 1'b0;
    logic          char_valid, char_last, index_rewind;
    logic [7:0]    char_data;
    logic [31:0]   strings_done;
`ifdef REM_FEEDER_TRUNC_EN
    logic          truncated;
`endif

    rem_string_feeder #(.WORD_BYTES(WB), .DELIMITER(DELIM), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_ready(out_ready), .abort(abort),
        .char_valid(char_valid), .char_data(char_data), .char_last(char_last),
        .index_rewind(index_rewind),
`ifdef REM_FEEDER_TRUNC_EN
        .truncated(truncated),
`endif
        .strings_done(strings_done));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected characters derived from the accepted words.
    typedef struct packed { logic tr; logic last; logic [7:0] b; } exp_t;
    exp_t exp_q[$];
    bit   skipping   = 0;
    int   m_len      = 0;
    int   exp_done   = 0;
    bit   mon_en     = 0;
    bit   prev_abort = 0;
    int   n_chars    = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_flag = 1'b0;

    task automatic model_word(input logic [WB*8-1:0] d, input logic l);
        exp_t e;
        bit   nat, tr;
        if (skipping) begin
            if (l) skipping = 0;
            return;
        end
        for (int i = 0; i < WB; i++) begin
            e.b = d[i*8 +: 8];
            nat = (e.b == DELIM) || (l && i == WB - 1);
            m_len++;
            tr = 0;
`ifdef REM_FEEDER_TRUNC_EN
            if (!nat && m_len == MAXL) tr = 1;
`endif
            e.tr   = tr;
            e.last = nat || tr;
            exp_q.push_back(e);
            if (e.last) begin
                m_len    = 0;
                skipping = !l;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("index_rewind", index_rewind, prev_abort);
            if (char_valid) begin
                n_chars++;
                last_byte = char_data;
                last_flag = char_last;
                if (exp_q.size() == 0) begin
                    check("extra_char", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("char_data", char_data, e.b);
                    check("char_last", char_last, e.last);
`ifdef REM_FEEDER_TRUNC_EN
                    check("truncated", truncated, e.tr);
`endif
                    if (e.last) begin
                        exp_done++;
                        check("strings_done", strings_done, exp_done);
                    end
                end
            end else begin
                check("last_when_idle", char_last, 1'b0);
            end
            prev_abort = abort;
            if (abort) begin
                exp_q.delete();
                skipping = 0;
                m_len    = 0;
            end else if (in_valid && in_ready) begin
                model_word(in_data, in_last);
            end
        end
    end

    function automatic logic [WB*8-1:0] str8(input string s);
        logic [WB*8-1:0] w = '0;
        for (int i = 0; i < WB; i++) w[i*8 +: 8] = s[i];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WB*8-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    logic [WB*8-1:0] w1, w2;
    int s_exp = 0;
    int c0;
    bit rand_done = 0;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_char_valid", char_valid, 1'b0);
        check("rst_char_data", char_data, 8'h00);
        check("rst_char_last", char_last, 1'b0);
        check("rst_index_rewind", index_rewind, 1'b0);
        check("rst_strings_done", strings_done, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);
        tick();
        rst = 1'b0;
        mon_en = 1;
        tick();

`ifdef REM_FEEDER_TRUNC_EN
        // Truncation at MAX_LEN=4
        send_word(str8("abcdefgh"), 1'b1);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("tr_valid", char_valid, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) begin
                check("tr_data", char_data, 8'(8'h61 + k - 1));
                check("tr_last", char_last, (k == 4));
                check("tr_pulse", truncated, (k == 4));
            end
        end
        s_exp++;
        check("tr_done", strings_done, s_exp);
        tick();
`else
        // Single in_last word, byte timing
        send_word(str8("abcdefgh"), 1'b1);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check("t1_valid", char_valid, (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) begin
                check("t1_data", char_data, 8'(8'h61 + k - 1));
                check("t1_last", char_last, (k == 8));
            end
        end
        s_exp++;
        check("t1_done", strings_done, s_exp);
        tick();
`endif

        // Delimiter mid-word, following word skipped
        w1 = str8("abcZxxxx");
        w1[31:24] = DELIM;
        c0 = n_chars;
        send_word(w1, 1'b0);
        send_word(str8("yyyyyyyy"), 1'b1);
        repeat (12) @(negedge clk);
        s_exp++;
        check("t2_nchars", n_chars - c0, 32'd4);
        check("t2_last_byte", last_byte, DELIM);
        check("t2_last_flag", last_flag, 1'b1);
        check("t2_done", strings_done, s_exp);
        check("t2_ready", in_ready, 1'b1);
        tick();

`ifndef REM_FEEDER_TRUNC_EN
        // Stall of 3 cycles after "c"
        send_word(str8("abcdefgh"), 1'b1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) out_ready = 1'b0;
            if (k == 6) out_ready = 1'b1;
            @(negedge clk);
            check("t3_valid", char_valid, (k <= 3 || k >= 7));
            if (k <= 3) check("t3_data", char_data, 8'(8'h61 + k - 1));
            if (k >= 7) check("t3_data", char_data, 8'(8'h61 + k - 4));
            if (k <= 3 || k >= 7) check("t3_last", char_last, (k == 11));
            check("t3_ready", in_ready, (k >= 10));
        end
        s_exp++;
        check("t3_done", strings_done, s_exp);
        tick();

        // Abort while "e" is on the char interface
        send_word(str8("abcdefgh"), 1'b1);
        repeat (5) tick();
        abort = 1'b1;
        @(negedge clk);
        check("t4_e", char_data, 8'h65);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t4_rewind", index_rewind, 1'b1);
        check("t4_valid", char_valid, 1'b0);
        check("t4_ready", in_ready, 1'b1);
        check("t4_done", strings_done, s_exp);
        tick();
        @(negedge clk);
        check("t4_rewind_pulse", index_rewind, 1'b0);
        tick();
        send_word(str8("ijklmnop"), 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t4_restart_valid", char_valid, 1'b1);
        check("t4_restart_data", char_data, 8'h69);
        repeat (10) @(negedge clk);
        s_exp++;
        check("t4_done2", strings_done, s_exp);
        tick();

        // Back-to-back in_last words, no bubble
        w1 = str8("ABCDEFGH");
        w2 = str8("IJKLMNOP");
        send_word(w1, 1'b1);
        fork
            send_word(w2, 1'b1);
            for (int k = 0; k <= 17; k++) begin
                @(negedge clk);
                check("t5_valid", char_valid, (k >= 1 && k <= 16));
                if (k >= 1 && k <= 16) begin
                    check("t5_data", char_data, (k <= 8) ? w1[(k-1)*8 +: 8] : w2[(k-9)*8 +: 8]);
                    check("t5_last", char_last, (k == 8 || k == 16));
                end
            end
        join
        s_exp += 2;
        check("t5_done", strings_done, s_exp);
        tick();
`endif

        // Randomized words, gaps, stalls and aborts
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [WB*8-1:0] w;
                    if ($urandom_range(0, 24) == 0) begin
                        abort = 1'b1;
                        tick();
                        abort = 1'b0;
                    end
                    repeat ($urandom_range(0, 2)) tick();
                    for (int i = 0; i < WB; i++)
                        w[i*8 +: 8] = ($urandom_range(0, 11) == 0) ? DELIM : 8'($urandom);
                    send_word(w, ($urandom_range(0, 2) == 0));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("rand_drain", exp_q.size(), 32'd0);
        check("rand_done", strings_done, exp_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
